// File: rtl/mpmc12_wdata_stager.sv
// mpmc12_wdata_stager
//   Captures one write line (BURST beats of WID data plus WID/8 byte masks)
//   from one of NCH channels on a load strobe, then streams it out one beat
//   at a time toward the DRAM write datapath.
//
// Handshake: a beat transfers on a rising edge where dato_valid && dato_ready.
//   While dato_valid=1 and dato_ready=0, dato/selo/beat hold. dato_ready is
//   ignored while dato_valid=0. dato/selo are only meaningful when qualified
//   by dato_valid; they keep the last beat after a line completes.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   ld, ch             load strobe and channel select
//   dati, seli         flattened channel lines / byte masks,
//                      channel c beat b at [(c*BURST+b)*WID +: WID]
//   dato, selo         current beat data / byte mask
//   dato_valid/ready   downstream beat handshake
//   beat, last         current beat index, final-beat flag
//   busy               a line is held or being sent
//   done               one-cycle pulse after the final beat is accepted
//   ld_err             one-cycle pulse when a load is rejected
//
// Optional feature macro: MPMC12_WDATA_PINGPONG_EN
//   Adds a pending line slot so one further line can be accepted while a line
//   is in flight; it follows the current line with no bubble.

module mpmc12_wdata_stager #(
  parameter int WID   = 256,
  parameter int NCH   = 4,
  parameter int BURST = 4,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int BW   = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ld,
  input  logic [CHW-1:0]              ch,
  input  logic [NCH*BURST*WID-1:0]    dati,
  input  logic [NCH*BURST*WID/8-1:0]  seli,
  output logic [WID-1:0]              dato,
  output logic [WID/8-1:0]            selo,
  output logic                        dato_valid,
  input  logic                        dato_ready,
  output logic [BW-1:0]               beat,
  output logic                        last,
  output logic                        busy,
  output logic                        done,
  output logic                        ld_err
);

  localparam int SW = WID / 8;
  localparam int LW = BURST * WID;
  localparam int MW = BURST * SW;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [WID-1:0]  dato_q, dato_d;
  logic [SW-1:0]   selo_q, selo_d;
  logic [LW-1:0]   line_q, line_d;
  logic [MW-1:0]   mask_q, mask_d;
  logic            done_q, done_d;
  logic            ld_err_q, ld_err_d;

  logic            ch_ok;
  logic            hs;
  logic            is_last;
  logic            ld_ok;
  logic [LW-1:0]   cap_line;
  logic [MW-1:0]   cap_mask;

`ifdef MPMC12_WDATA_PINGPONG_EN
  logic            pend_q, pend_d;
  logic [LW-1:0]   pline_q, pline_d;
  logic [MW-1:0]   pmask_q, pmask_d;
`endif

  assign ch_ok    = int'(ch) < NCH;
  assign cap_line = dati[int'(ch)*LW +: LW];
  assign cap_mask = seli[int'(ch)*MW +: MW];
  // dato_valid is exactly "in SEND", so the handshake needs only ready.
  assign hs       = (state_q == SEND) && dato_ready;
  assign is_last  = (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    dato_d  = dato_q;
    selo_d  = selo_q;
    line_d  = line_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    ld_ok   = 1'b0;
`ifdef MPMC12_WDATA_PINGPONG_EN
    pend_d  = pend_q;
    pline_d = pline_q;
    pmask_d = pmask_q;
`endif
    case (state_q)
      IDLE: begin
        if (ld && ch_ok) begin
          ld_ok   = 1'b1;
          state_d = SEND;
          beat_d  = '0;
          line_d  = cap_line;
          mask_d  = cap_mask;
          dato_d  = cap_line[WID-1:0];
          selo_d  = cap_mask[SW-1:0];
        end
      end
      SEND: begin
        if (hs && is_last) begin
          // Final beat accepted: the line retires; dato/selo keep the last beat.
          done_d  = 1'b1;
          beat_d  = '0;
          state_d = IDLE;
`ifdef MPMC12_WDATA_PINGPONG_EN
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = SEND;
            line_d  = pline_q;
            mask_d  = pmask_q;
            dato_d  = pline_q[WID-1:0];
            selo_d  = pmask_q[SW-1:0];
          end else if (ld && ch_ok) begin
            // A load landing on the final handshake starts straight away.
            ld_ok   = 1'b1;
            state_d = SEND;
            line_d  = cap_line;
            mask_d  = cap_mask;
            dato_d  = cap_line[WID-1:0];
            selo_d  = cap_mask[SW-1:0];
          end
`endif
        end else begin
          if (hs) begin
            beat_d = beat_q + BW'(1);
            dato_d = line_q[(int'(beat_q) + 1)*WID +: WID];
            selo_d = mask_q[(int'(beat_q) + 1)*SW +: SW];
          end
`ifdef MPMC12_WDATA_PINGPONG_EN
          if (ld && ch_ok && !pend_q) begin
            ld_ok   = 1'b1;
            pend_d  = 1'b1;
            pline_d = cap_line;
            pmask_d = cap_mask;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Any load not taken (bad channel, or no room) reports one error pulse.
    ld_err_d = ld && !ld_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      dato_q   <= '0;
      selo_q   <= '0;
      line_q   <= '0;
      mask_q   <= '0;
      done_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      dato_q   <= dato_d;
      selo_q   <= selo_d;
      line_q   <= line_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
      ld_err_q <= ld_err_d;
    end
  end

`ifdef MPMC12_WDATA_PINGPONG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      pline_q <= '0;
      pmask_q <= '0;
    end else begin
      pend_q  <= pend_d;
      pline_q <= pline_d;
      pmask_q <= pmask_d;
    end
  end
  assign busy = (state_q == SEND) || pend_q;
`else
  assign busy = (state_q == SEND);
`endif

  assign dato       = dato_q;
  assign selo       = selo_q;
  assign dato_valid = (state_q == SEND);
  assign beat       = beat_q;
  assign last       = (state_q == SEND) && is_last;
  assign done       = done_q;
  assign ld_err     = ld_err_q;

endmodule

// File: tb/tb_mpmc12_wdata_stager.sv
// Bench for mpmc12_wdata_stager (WID=32, NCH=3, BURST=4).
// Expected beats are queued when a load is expected to be accepted and are
// popped by a negedge monitor on every handshake; tasks check latency,
// errors, hold behaviour and pingpong/no-pingpong differences inline.

module tb_mpmc12_wdata_stager;

  localparam int WID   = 32;
  localparam int NCH   = 3;
  localparam int BURST = 4;
  localparam int CHW   = 2;
  localparam int BW    = 2;
  localparam int SW    = WID / 8;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        ld = 1'b0;
  logic [CHW-1:0]              ch = '0;
  logic [NCH*BURST*WID-1:0]    dati = '0;
  logic [NCH*BURST*SW-1:0]     seli = '0;
  logic [WID-1:0]              dato;
  logic [SW-1:0]               selo;
  logic                        dato_valid;
  logic                        dato_ready = 1'b0;
  logic [BW-1:0]               beat;
  logic                        last;
  logic                        busy;
  logic                        done;
  logic                        ld_err;

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [WID-1:0] exp_q[$];
  logic [SW-1:0]  exp_sel_q[$];
  int             hs_cnt = 0;
  int             hs_total = 0;
  logic           done_next = 1'b0;
  logic           stall_prev = 1'b0;
  logic [WID-1:0] prev_dato = '0;
  logic [BW-1:0]  prev_beat = '0;
  logic [WID-1:0] mon_d;
  logic [SW-1:0]  mon_s;

  mpmc12_wdata_stager #(.WID(WID), .NCH(NCH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .ch(ch), .dati(dati), .seli(seli),
    .dato(dato), .selo(selo), .dato_valid(dato_valid), .dato_ready(dato_ready),
    .beat(beat), .last(last), .busy(busy), .done(done), .ld_err(ld_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // monitor: beat order, beat index/last, done timing, hold under stall
  always @(negedge clk) begin
    if (!rst_n) begin
      done_next  = 1'b0;
      hs_cnt     = 0;
      stall_prev = 1'b0;
    end else begin
      checks++;
      if (done !== done_next) begin
        errors++;
        $display("FAIL done_timing: done=%b want %b at %0t", done, done_next, $time);
      end
      if (stall_prev) begin
        checks++;
        if (dato_valid !== 1'b1 || dato !== prev_dato || beat !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold: valid=%b dato=%h beat=%0d want valid=1 dato=%h beat=%0d",
                   dato_valid, dato, beat, prev_dato, prev_beat);
        end
      end
      done_next = 1'b0;
      if (dato_valid === 1'b1 && dato_ready === 1'b1) begin
        hs_total++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: dato=%h with no beat expected", dato);
        end else begin
          mon_d = exp_q.pop_front();
          mon_s = exp_sel_q.pop_front();
          if (dato !== mon_d || selo !== mon_s) begin
            errors++;
            $display("FAIL beat_data: dato=%h selo=%h want dato=%h selo=%h", dato, selo, mon_d, mon_s);
          end
        end
        checks++;
        if (beat !== BW'(hs_cnt) || last !== (hs_cnt == BURST - 1)) begin
          errors++;
          $display("FAIL beat_index: beat=%0d last=%b want beat=%0d last=%b",
                   beat, last, hs_cnt, (hs_cnt == BURST - 1));
        end
        if (hs_cnt == BURST - 1) begin
          hs_cnt    = 0;
          done_next = 1'b1;
        end else begin
          hs_cnt++;
        end
      end
      stall_prev = (dato_valid === 1'b1) && (dato_ready === 1'b0);
      prev_dato  = dato;
      prev_beat  = beat;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int c, input logic [WID-1:0] base, input bit rnd);
    for (int b = 0; b < BURST; b++) begin
      dati[(c*BURST+b)*WID +: WID] = rnd ? WID'($urandom) : base + WID'(b);
      seli[(c*BURST+b)*SW +: SW]   = rnd ? SW'($urandom_range(0, (1 << SW) - 1)) : {SW{1'b1}};
    end
  endtask

  task automatic push_line(input int c);
    for (int b = 0; b < BURST; b++) begin
      exp_q.push_back(dati[(c*BURST+b)*WID +: WID]);
      exp_sel_q.push_back(seli[(c*BURST+b)*SW +: SW]);
    end
  endtask

  task automatic pulse_ld(input int c);
    ld = 1'b1;
    ch = CHW'(c);
    step();
    ld = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input bit rnd_ready);
    int n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      if (rnd_ready) dato_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles want 0", busy, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL beats_missing: %0d beats left want 0", exp_q.size());
    end
    dato_ready = 1'b0;
    step();
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (dato !== '0 || selo !== '0 || beat !== '0) begin
      errors++;
      $display("FAIL reset_data: dato=%h selo=%h beat=%0d want 0", dato, selo, beat);
    end
    checks++;
    if (dato_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ld_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b last=%b busy=%b done=%b ld_err=%b want all 0",
               dato_valid, last, busy, done, ld_err);
    end
    step();
  endtask

  task automatic test_basic_line();
    set_line(2, 32'hA0, 1'b0);
    push_line(2);
    dato_ready = 1'b1;
    pulse_ld(2);
    checks++;
    if (dato_valid !== 1'b1 || busy !== 1'b1 || beat !== 2'd0 || dato !== 32'hA0) begin
      errors++;
      $display("FAIL basic_latency: valid=%b busy=%b beat=%0d dato=%h want 1 1 0 a0",
               dato_valid, busy, beat, dato);
    end
    repeat (3) step();
    checks++;
    if (beat !== 2'd3 || last !== 1'b1 || dato !== 32'hA3) begin
      errors++;
      $display("FAIL basic_last: beat=%0d last=%b dato=%h want 3 1 a3", beat, last, dato);
    end
    step();
    checks++;
    if (done !== 1'b1 || dato_valid !== 1'b0 || busy !== 1'b0 || beat !== 2'd0 || dato !== 32'hA3) begin
      errors++;
      $display("FAIL basic_done: done=%b valid=%b busy=%b beat=%0d dato=%h want 1 0 0 0 a3",
               done, dato_valid, busy, beat, dato);
    end
    wait_idle(10, 1'b0);
  endtask

  task automatic test_backpressure();
    int h0;
    h0 = hs_total;
    set_line(2, 32'hA0, 1'b0);
    push_line(2);
    dato_ready = 1'b1;
    pulse_ld(2);
    step();
    dato_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dato_valid !== 1'b1 || beat !== 2'd1 || dato !== 32'hA1) begin
        errors++;
        $display("FAIL backpressure_hold: valid=%b beat=%0d dato=%h want 1 1 a1", dato_valid, beat, dato);
      end
      if (i < 3) step();
    end
    dato_ready = 1'b1;
    wait_idle(20, 1'b0);
    checks++;
    if (hs_total - h0 != BURST) begin
      errors++;
      $display("FAIL backpressure_count: %0d handshakes want %0d", hs_total - h0, BURST);
    end
  endtask

  task automatic test_invalid_channel();
    pulse_ld(3);
    checks++;
    if (ld_err !== 1'b1 || busy !== 1'b0 || dato_valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_ch: ld_err=%b busy=%b valid=%b want 1 0 0", ld_err, busy, dato_valid);
    end
    step();
    checks++;
    if (ld_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL invalid_ch_pulse: ld_err=%b busy=%b want 0 0", ld_err, busy);
    end
  endtask

  task automatic test_load_while_busy();
    int n = 0;
    set_line(0, 32'hB0, 1'b0);
    set_line(1, 32'hC0, 1'b0);
    push_line(0);
    dato_ready = 1'b1;
    pulse_ld(0);
    step();
    step();
`ifdef MPMC12_WDATA_PINGPONG_EN
    push_line(1);
`endif
    pulse_ld(1);
`ifdef MPMC12_WDATA_PINGPONG_EN
    checks++;
    if (ld_err !== 1'b0) begin
      errors++;
      $display("FAIL busy_ld_err: ld_err=%b want 0", ld_err);
    end
`else
    checks++;
    if (ld_err !== 1'b1) begin
      errors++;
      $display("FAIL busy_ld_err: ld_err=%b want 1", ld_err);
    end
`endif
    while (done !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL busy_done: done=%b want 1", done);
    end
`ifdef MPMC12_WDATA_PINGPONG_EN
    checks++;
    if (dato_valid !== 1'b1 || busy !== 1'b1 || beat !== 2'd0 || dato !== 32'hC0) begin
      errors++;
      $display("FAIL busy_next_line: valid=%b busy=%b beat=%0d dato=%h want 1 1 0 c0",
               dato_valid, busy, beat, dato);
    end
`else
    checks++;
    if (dato_valid !== 1'b0 || busy !== 1'b0 || dato !== 32'hB3) begin
      errors++;
      $display("FAIL busy_no_next: valid=%b busy=%b dato=%h want 0 0 b3", dato_valid, busy, dato);
    end
`endif
    wait_idle(20, 1'b0);
  endtask

  task automatic test_ld_on_last();
    set_line(0, 32'h50, 1'b0);
    set_line(1, 32'h60, 1'b0);
    push_line(0);
    dato_ready = 1'b1;
    pulse_ld(0);
    repeat (3) step();
    checks++;
    if (last !== 1'b1) begin
      errors++;
      $display("FAIL onlast_setup: last=%b want 1", last);
    end
`ifdef MPMC12_WDATA_PINGPONG_EN
    push_line(1);
`endif
    pulse_ld(1);
`ifdef MPMC12_WDATA_PINGPONG_EN
    checks++;
    if (done !== 1'b1 || ld_err !== 1'b0 || dato_valid !== 1'b1 || dato !== 32'h60) begin
      errors++;
      $display("FAIL onlast_accept: done=%b ld_err=%b valid=%b dato=%h want 1 0 1 60",
               done, ld_err, dato_valid, dato);
    end
`else
    checks++;
    if (done !== 1'b1 || ld_err !== 1'b1 || dato_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL onlast_reject: done=%b ld_err=%b valid=%b busy=%b want 1 1 0 0",
               done, ld_err, dato_valid, busy);
    end
`endif
    wait_idle(20, 1'b0);
  endtask

  task automatic test_data_isolation();
    set_line(2, 32'hA0, 1'b0);
    push_line(2);
    dato_ready = 1'b0;
    pulse_ld(2);
    for (int b = 0; b < BURST; b++) dati[(2*BURST+b)*WID +: WID] = 32'hFFFF_FFFF;
    step();
    dato_ready = 1'b1;
    wait_idle(20, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    set_line(1, 32'h10, 1'b0);
    push_line(1);
    dato_ready = 1'b1;
    pulse_ld(1);
    while (beat !== 2'd2 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (beat !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_setup: beat=%0d want 2", beat);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dato_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: valid=%b busy=%b want 0 0", dato_valid, busy);
    end
    exp_q.delete();
    exp_sel_q.delete();
    dato_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_nodone: done=%b busy=%b want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 10; i++) begin
      c = $urandom_range(0, NCH - 1);
      set_line(c, '0, 1'b1);
      push_line(c);
      dato_ready = 1'($urandom_range(0, 1));
      pulse_ld(c);
      checks++;
      if (ld_err !== 1'b0 || dato_valid !== 1'b1) begin
        errors++;
        $display("FAIL random_accept: ld_err=%b valid=%b want 0 1", ld_err, dato_valid);
      end
      wait_idle(200, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_backpressure();
    test_invalid_channel();
    test_load_while_busy();
    test_ld_on_last();
    test_data_isolation();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpmc12_wdata_stager.md
Name: mpmc12_wdata_stager

Overview:
- Parametrised successor to the single-shot write-data latch in the multi-port memory controller.
- Captures one write line (BURST beats plus byte masks) from one of NCH channels on a load strobe.
- Serialises the line to the PHY write path one beat at a time over a valid/ready handshake.
- Sits between the channel arbiter/state machine and the DRAM write datapath.

Parameters:
- WID, 256, beat data width in bits; multiple of 8.
- NCH, 4, number of requesting channels; 1..16.
- BURST, 4, beats per line; power of 2, 1..16.
- CHW, $clog2(NCH) (min 1), channel index width; derived, do not override.
- BW, $clog2(BURST) (min 1), beat counter width; derived, do not override.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld  in  1  load strobe; capture line from channel ch.
- ch  in  CHW  channel select for ld.
- dati  in  NCH*BURST*WID  flattened channel lines; channel c beat b at bits [(c*BURST+b)*WID +: WID].
- seli  in  NCH*BURST*WID/8  flattened byte masks; same indexing at WID/8 granularity.
- dato  out  WID  current beat data.
- selo  out  WID/8  current beat byte mask.
- dato_valid  out  1  beat on dato/selo valid.
- dato_ready  in  1  downstream accepts beat.
- beat  out  BW  index of current beat.
- last  out  1  current beat is beat BURST-1.
- busy  out  1  line held or being sent.
- done  out  1  one-cycle pulse after the final beat is accepted.
- ld_err  out  1  one-cycle pulse when ld is rejected.

Behaviour:
- Reset: async assert drives dato=0, selo=0, dato_valid=0, beat=0, last=0, busy=0, done=0, ld_err=0; state=IDLE; buffers cleared. Reset mid-burst abandons the line; no done is generated.
- States: IDLE, SEND.
- IDLE, ld=1, ch<NCH:
  - Capture dati and seli for channel ch into the line buffer.
  - Next cycle: state=SEND, busy=1, dato_valid=1, beat=0, dato/selo = beat 0. Load-to-valid latency is 1 cycle.
- IDLE, ld=1, ch>=NCH: no capture; ld_err=1 for one cycle; remain in IDLE.
- SEND: dato, selo and beat are stable while dato_valid=1 and dato_ready=0.
- Handshake dato_valid&dato_ready on beat k<BURST-1: next cycle beat=k+1 and dato/selo = beat k+1. No bubble.
- last = dato_valid && beat==BURST-1.
- Handshake on the last beat:
  - next cycle: state=IDLE, dato_valid=0, busy=0, done=1 for one cycle, beat=0.
  - dato/selo hold their last values. Only dato_valid qualifies them.
- BURST=1: a single beat with last=1 on the first valid cycle.
- dato_ready while dato_valid=0 is ignored.
- ld while busy=1 (includes the cycle of the final handshake): rejected; ld_err=1 for one cycle. The current line is unaffected.
- Simultaneous ld and ch>=NCH while busy: a single ld_err pulse.
- The line buffer is written only on an accepted ld. Changes on dati/seli after capture do not affect the line in flight.

Optional Feature:
- Macro MPMC12_WDATA_PINGPONG_EN.
- Defined:
  - Adds a second line buffer (pending slot) and an internal pend flag.
  - ld with ch<NCH while busy and pend=0 is accepted into the pending slot; no ld_err.
  - On the final handshake with pend=1: next cycle done=1, busy stays 1, dato_valid stays 1, beat=0, dato/selo = pending beat 0. pend clears. No bubble between lines.
  - ld in the same cycle as the final handshake with pend=0 is accepted and behaves identically.
  - ld while pend=1: rejected with ld_err.
  - busy = (state==SEND) || pend.
- Not defined: single buffer; behaviour exactly as in Behaviour; no pending storage is synthesised.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> all outputs 0, busy=0. Assert rst_n=0 mid-burst at beat 2 -> dato_valid=0 and busy=0 asynchronously; no done pulse.
- Basic line: NCH=4, BURST=4, ld with ch=2, channel-2 beats 0xA0..0xA3, masks all-ones, dato_ready held 1 -> dato_valid from cycle+1 for 4 cycles; beats 0xA0,0xA1,0xA2,0xA3; last on the 4th; done on cycle+5.
- Backpressure: same load, dato_ready=0 for 3 cycles on beat 1 -> dato=0xA1 and beat=1 stable throughout; full sequence still completes with exactly 4 handshakes.
- Invalid channel: NCH=3, ld with ch=3 in IDLE -> ld_err pulse; busy stays 0; dato_valid stays 0.
- Load while busy: ld with ch=1 during beat 2 of a ch=0 line -> without the macro, ld_err=1 and ch=0 beats are unaltered; with MPMC12_WDATA_PINGPONG_EN, no ld_err and ch=1 beat 0 appears on the cycle after the ch=0 last handshake, coincident with done.
- Data isolation: change channel-2 dati to 0xFF.. one cycle after capture -> output beats remain 0xA0..0xA3.
